detector_stream_sequencer: RTL and testbench

Control-and-gating block for the thermal detector front end. It sequences detector power-up (reset pulse, then settle time) and waits for the first frame start. It then forwards the detector's Avalon-ST pixel stream downstream in whole frames only, either continuously or for a programmed number of frames. Software controls it through a small Avalon-MM register slave and gets a frame-done/timeout interrupt.

---
 rtl/detector_stream_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_detector_stream_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_stream_sequencer.sv
// Power-up sequencer and whole-frame gate for the thermal detector stream,
// with a small Avalon-MM register slave and a frame-done/timeout interrupt.
module detector_stream_sequencer #(
  parameter int RST_CYCLES     = 1000,
  parameter int SETTLE_CYCLES  = 50000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  output logic [31:0] av_readdata,
  input  logic        din_startofpacket,
  input  logic        din_endofpacket,
  input  logic        din_valid,
  input  logic [13:0] din_data,
  output logic        dout_startofpacket,
  output logic        dout_endofpacket,
  output logic        dout_valid,
  output logic [13:0] dout_data,
  output logic        dd_nrst,
  output logic        dd_i2cad,
  output logic        irq
);

  localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(PH_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0]   LEN_MAX     = 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_SETTLE = 3'd2,
    S_SYNC   = 3'd3,
    S_STREAM = 3'd4
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] phase_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic          go_reg, single_reg, i2cad_reg;
  logic [15:0]   nframes_reg, shot_cnt_reg;
  logic          timeout_err_reg, irq_en_reg, irq_pending_reg;
  logic [31:0]   frames_reg;
  logic [23:0]   lastlen_reg, len_reg;

  logic [7:0] wr_sel;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wr_sel
      assign wr_sel[gi] = av_write && (av_address == 3'(gi));
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{av_writedata[31:16], wr_sel[7:5], wr_sel[3:2]};

  logic        live, stop_wr, start_wr, go_now, fwd, eop_fwd, to_hit, shot_end, frame_stop;
  logic [15:0] shot_next, nframes_eff;
  logic [23:0] len_now;
  logic [31:0] rd_word;

  always_comb begin
    live        = (state_reg == S_SYNC) || (state_reg == S_STREAM);
    stop_wr     = wr_sel[0] && !av_writedata[0];
    start_wr    = wr_sel[0] && av_writedata[0] && (state_reg == S_IDLE);
    // A stop written in the same cycle as an eop still ends on that eop.
    go_now      = go_reg && !stop_wr;
    fwd         = din_valid && (((state_reg == S_SYNC) && din_startofpacket && !stop_wr) ||
                                (state_reg == S_STREAM));
    eop_fwd     = fwd && din_endofpacket;
    to_hit      = live && !din_valid && (to_cnt_reg == TO_LAST);
    shot_next   = shot_cnt_reg + 16'd1;
    nframes_eff = (nframes_reg == 16'd0) ? 16'd1 : nframes_reg;
    shot_end    = single_reg && (shot_next >= nframes_eff);
    frame_stop  = eop_fwd && (shot_end || !go_now);
    len_now     = (len_reg == LEN_MAX) ? LEN_MAX : len_reg + 24'd1;
  end

  always_comb begin
    rd_word = 32'd0;
    case (av_address)
      3'd0:    rd_word = {29'd0, i2cad_reg, single_reg, go_reg};
      3'd1:    rd_word = {16'd0, nframes_reg};
      3'd2:    rd_word = {27'd0, timeout_err_reg, 1'b0, state_reg};
      3'd3:    rd_word = frames_reg;
      3'd4:    rd_word = {30'd0, irq_pending_reg, irq_en_reg};
      3'd5:    rd_word = {8'd0, lastlen_reg};
      default: rd_word = 32'd0;
    endcase
  end

  assign dd_i2cad = i2cad_reg;
  assign irq      = irq_en_reg & irq_pending_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= S_IDLE;
      phase_cnt_reg      <= '0;
      to_cnt_reg         <= '0;
      go_reg             <= 1'b0;
      single_reg         <= 1'b0;
      i2cad_reg          <= 1'b0;
      nframes_reg        <= 16'd0;
      shot_cnt_reg       <= 16'd0;
      timeout_err_reg    <= 1'b0;
      irq_en_reg         <= 1'b0;
      irq_pending_reg    <= 1'b0;
      frames_reg         <= 32'd0;
      lastlen_reg        <= 24'd0;
      len_reg            <= 24'd0;
      av_readdata        <= 32'd0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      dout_valid         <= 1'b0;
      dout_data          <= 14'd0;
      dd_nrst            <= 1'b0;
    end else begin
      if (wr_sel[0]) begin
        single_reg <= av_writedata[1];
        i2cad_reg  <= av_writedata[2];
        if (state_reg == S_IDLE)
          go_reg <= av_writedata[0];
        else if (!av_writedata[0])
          go_reg <= 1'b0;
        if (av_writedata[0])
          timeout_err_reg <= 1'b0;
      end
      if (wr_sel[1])
        nframes_reg <= av_writedata[15:0];
      if (wr_sel[4]) begin
        irq_en_reg <= av_writedata[0];
        if (av_writedata[1])
          irq_pending_reg <= 1'b0;
      end
      if (av_read)
        av_readdata <= rd_word;

      dout_valid         <= fwd;
      dout_startofpacket <= fwd && din_startofpacket;
      dout_endofpacket   <= eop_fwd;
      if (fwd)
        dout_data <= din_data;

      if (!live)
        len_reg <= 24'd0;
      else if (fwd)
        len_reg <= din_endofpacket ? 24'd0 : len_now;

      // Pending-set events come after the clear write so that set wins.
      if (eop_fwd) begin
        frames_reg      <= frames_reg + 32'd1;
        lastlen_reg     <= len_now;
        shot_cnt_reg    <= shot_next;
        irq_pending_reg <= 1'b1;
      end
      if (start_wr) begin
        frames_reg   <= 32'd0;
        shot_cnt_reg <= 16'd0;
      end

      if (live && !din_valid)
        to_cnt_reg <= to_cnt_reg + 1'b1;
      else
        to_cnt_reg <= '0;
      if (to_hit) begin
        timeout_err_reg <= 1'b1;
        irq_pending_reg <= 1'b1;
      end
      if (to_hit || (eop_fwd && shot_end))
        go_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          dd_nrst <= 1'b0;
          if (start_wr) begin
            state_reg     <= S_RESET;
            phase_cnt_reg <= '0;
          end
        end
        S_RESET: begin
          if (stop_wr) begin
            state_reg <= S_IDLE;
          end else if (phase_cnt_reg == RST_LAST) begin
            state_reg     <= S_SETTLE;
            phase_cnt_reg <= '0;
            dd_nrst       <= 1'b1;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        S_SETTLE: begin
          if (stop_wr) begin
            state_reg <= S_IDLE;
            dd_nrst   <= 1'b0;
          end else if (phase_cnt_reg == SETTLE_LAST) begin
            state_reg <= S_SYNC;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        S_SYNC: begin
          if (stop_wr || to_hit || frame_stop) begin
            state_reg <= S_IDLE;
            dd_nrst   <= 1'b0;
          end else if (fwd) begin
            state_reg <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (to_hit || frame_stop) begin
            state_reg <= S_IDLE;
            dd_nrst   <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          dd_nrst   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_stream_sequencer.sv
// Randomized scoreboard bench for detector_stream_sequencer against a
// timeline-based reference model of the sequencing and gating rules.
module tb_detector_stream_sequencer;
  localparam int RST = 4;
  localparam int SETTLE = 8;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  av_address = '0;
  logic        av_read = 1'b0, av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic [31:0] av_readdata;
  logic        din_startofpacket = 1'b0, din_endofpacket = 1'b0, din_valid = 1'b0;
  logic [13:0] din_data = '0;
  logic        dout_startofpacket, dout_endofpacket, dout_valid;
  logic [13:0] dout_data;
  logic        dd_nrst, dd_i2cad, irq;

  always #5 clk = ~clk;

  detector_stream_sequencer #(
    .RST_CYCLES(RST), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .din_startofpacket(din_startofpacket), .din_endofpacket(din_endofpacket),
    .din_valid(din_valid), .din_data(din_data),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .dout_valid(dout_valid), .dout_data(dout_data),
    .dd_nrst(dd_nrst), .dd_i2cad(dd_i2cad), .irq(irq)
  );

  typedef struct {
    logic        sop;
    logic        eop;
    logic [13:0] data;
    int          at;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Reference model: the run is a timeline anchored at the go edge m_c0.
  bit          m_run, m_strm, m_go, m_single, m_i2c, m_en, m_pend, m_err;
  int          m_c0, m_last_act, m_nfr, m_shots, m_len, m_lastlen;
  logic [31:0] m_frames;

  task automatic model_reset();
    m_run = 0; m_strm = 0; m_go = 0; m_single = 0; m_i2c = 0; m_en = 0; m_pend = 0; m_err = 0;
    m_c0 = 0; m_last_act = 0; m_nfr = 0; m_shots = 0; m_len = 0; m_lastlen = 0; m_frames = '0;
  endtask

  function automatic int code_at(int k);
    if (!m_run) return 0;
    if (k < m_c0 + RST) return 1;
    if (k < m_c0 + RST + SETTLE) return 2;
    return m_strm ? 4 : 3;
  endfunction

  function automatic logic [31:0] model_read(logic [2:0] a, int k);
    case (a)
      3'd0:    return {29'd0, m_i2c, m_single, m_go};
      3'd1:    return 32'(m_nfr);
      3'd2:    return {27'd0, m_err, 1'b0, 3'(code_at(k))};
      3'd3:    return m_frames;
      3'd4:    return {30'd0, m_pend, m_en};
      3'd5:    return 32'(m_lastlen);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [13:0] d,
                      input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] wd);
    int en, cur;
    bit live, stopw, fwd, tohit, go_now, shot_end;
    logic [31:0] exp_rd;
    din_valid = v; din_startofpacket = s; din_endofpacket = e; din_data = d;
    av_write = wr; av_read = rd; av_address = a; av_writedata = wd;
    en = edge_n + 1;
    cur = code_at(en - 1);
    exp_rd = model_read(a, en - 1);
    live = (cur == 3) || (cur == 4);
    stopw = wr && (a == 3'd0) && !wd[0];
    fwd = v && (((cur == 3) && s && !stopw) || (cur == 4));
    tohit = live && !v && (en - m_last_act == TO);
    go_now = m_go && !stopw;
    shot_end = 0;
    if (live && v) m_last_act = en;
    if (fwd) begin
      exp_q.push_back('{sop: s, eop: e, data: d, at: en});
      if (m_len < 24'hFFFFFF) m_len++;
      if (cur == 3) m_strm = 1;
      if (e) begin
        m_frames = m_frames + 1;
        m_lastlen = m_len;
        m_len = 0;
        m_shots++;
        shot_end = m_single && (m_shots >= ((m_nfr == 0) ? 1 : m_nfr));
        if (shot_end || !go_now) begin m_run = 0; m_strm = 0; end
      end
    end
    if (wr && a == 3'd0) begin
      m_single = wd[1]; m_i2c = wd[2];
      if (wd[0]) m_err = 0;
      if (cur == 0) begin
        m_go = wd[0];
        if (wd[0]) begin
          m_run = 1; m_strm = 0; m_c0 = en; m_frames = '0; m_shots = 0; m_len = 0;
          m_last_act = en + RST + SETTLE;
        end
      end else if (!wd[0]) begin
        m_go = 0;
        if (cur != 4) m_run = 0;
      end
    end
    if (wr && a == 3'd1) m_nfr = int'(wd[15:0]);
    if (wr && a == 3'd4) begin
      m_en = wd[0];
      if (wd[1]) m_pend = 0;
    end
    if (fwd && e) m_pend = 1;
    if (shot_end) m_go = 0;
    if (tohit) begin m_err = 1; m_pend = 1; m_run = 0; m_strm = 0; m_go = 0; end
    @(posedge clk); #1;
    edge_n = en;
    check("dd_nrst", {31'd0, dd_nrst}, {31'd0, code_at(en) >= 2});
    check("irq", {31'd0, irq}, {31'd0, m_en & m_pend});
    check("dd_i2cad", {31'd0, dd_i2cad}, {31'd0, m_i2c});
    if (rd) check("av_readdata", av_readdata, exp_rd);
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, '0, 0, 0, 3'd0, '0);
  endtask

  task automatic poll(int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, '0, 0, 1, 3'd2, '0);
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    step(0, 0, 0, '0, 1, 0, a, d);
  endtask

  task automatic rd(logic [2:0] a);
    step(0, 0, 0, '0, 0, 1, a, '0);
  endtask

  task automatic frame(int len, int gap_max);
    for (int i = 0; i < len; i++) begin
      step(1, i == 0, i == len - 1, 14'($urandom), 0, 0, 3'd0, '0);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dout_unexpected: got beat sop=%0b eop=%0b data=0x%0h, expected none (edge %0d)",
                 dout_startofpacket, dout_endofpacket, dout_data, edge_n);
      end else begin
        mon_b = exp_q.pop_front();
        check("dout_beat", {17'd0, dout_startofpacket, dout_endofpacket, dout_data},
              {17'd0, mon_b.sop, mon_b.eop, mon_b.data});
        check("dout_latency", edge_n, mon_b.at);
      end
    end else if (rst_n) begin
      check("dout_idle_flags", {30'd0, dout_startofpacket, dout_endofpacket}, 32'd0);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout_data", {18'd0, dout_data}, 32'd0);
    check("rst_dd_nrst", {31'd0, dd_nrst}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_av_readdata", av_readdata, 32'd0);
    rst_n = 1'b1;
    idle(2);
    rd(3'd2); rd(3'd3); rd(3'd0);

    // Register basics: i2cad, unmapped reads, irq enable.
    wr(3'd0, 32'h4);
    rd(3'd6); rd(3'd7); rd(3'd0);
    wr(3'd4, 32'h1);

    // Power-up, then join mid-frame: the tail must be dropped.
    wr(3'd0, 32'h5);
    poll(RST + SETTLE + 1);
    for (int i = 5; i <= 9; i++) step(1, 0, i == 9, 14'($urandom), 0, 0, 3'd0, '0);
    frame(10, 0);
    rd(3'd3); rd(3'd5); rd(3'd2);
    repeat (6) frame($urandom_range(1, 12), 3);
    rd(3'd3); rd(3'd5);
    wr(3'd4, 32'h3);

    // Stop written on beat 4 of 10: the frame still completes.
    for (int i = 0; i < 10; i++) step(1, i == 0, i == 9, 14'($urandom), i == 3, 0, 3'd0, 32'h4);
    frame(5, 0);
    poll(2); rd(3'd0);

    // Stop written in the same cycle as the eop beat.
    wr(3'd0, 32'h1);
    idle(RST + SETTLE);
    for (int i = 0; i < 4; i++) step(1, i == 0, i == 3, 14'($urandom), i == 3, 0, 3'd0, 32'h0);
    frame(3, 0);
    poll(2); rd(3'd3);

    // Single-shot of 3 frames with 5 offered.
    wr(3'd1, 32'd3);
    wr(3'd0, 32'h3);
    idle(RST + SETTLE);
    repeat (5) frame($urandom_range(2, 8), 2);
    rd(3'd2); rd(3'd0); rd(3'd4); rd(3'd3);

    // NFRAMES=0 behaves as a single frame.
    wr(3'd1, 32'd0);
    wr(3'd0, 32'h3);
    idle(RST + SETTLE);
    repeat (2) frame(3, 1);
    rd(3'd3); rd(3'd2);

    // Timeout mid-frame with irq enabled, then clear and restart.
    wr(3'd4, 32'h3);
    wr(3'd0, 32'h1);
    idle(RST + SETTLE);
    step(1, 1, 0, 14'($urandom), 0, 0, 3'd0, '0);
    step(1, 0, 0, 14'($urandom), 0, 0, 3'd0, '0);
    poll(TO + 3);
    rd(3'd4);
    wr(3'd4, 32'h3);
    wr(3'd0, 32'h1);
    rd(3'd2);
    idle(5);
    wr(3'd0, 32'h0);
    poll(2);

    // Randomized soak of beats, register writes and reads.
    for (int c = 0; c < 1500; c++) begin
      logic v, s, e, w, r;
      logic [2:0] a;
      v = ($urandom_range(0, 2) != 0);
      s = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 5) == 0);
      w = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 3) == 0);
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) idle(TO + 2);
      step(v, s, e, 14'($urandom), w, r, a, 32'($urandom_range(0, 7)));
    end

    // Asynchronous reset in the middle of a forwarded frame.
    wr(3'd0, 32'h1);
    idle(RST + SETTLE);
    step(1, 1, 0, 14'($urandom), 0, 0, 3'd0, '0);
    step(1, 0, 0, 14'($urandom), 0, 0, 3'd0, '0);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("arst_dout_eop", {31'd0, dout_endofpacket}, 32'd0);
    check("arst_dd_nrst", {31'd0, dd_nrst}, 32'd0);
    model_reset();
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    idle(3);
    rd(3'd2);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
